// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg
//   Shared definitions for the fp_mult datapath and its result stage.
//   - Status-word bit indices. The 8-bit status is packed as
//     {0, 0, inexact, huge, tiny, nan, inf, zero}.
//   - Rounding-mode enum used by fp_mult.
//   - Status word type and a helper that extracts the six flag bits.
package fp_mult_pkg;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Number of meaningful flag bits in the status word; [7:6] are reserved.
  localparam int ST_FLAGS_W = 6;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,  // round to nearest, ties to even
    RM_RTZ = 2'd1,  // round toward zero
    RM_RUP = 2'd2,  // round toward +inf
    RM_RDN = 2'd3   // round toward -inf
  } rnd_mode_e;

  typedef logic [7:0] status_t;

  function automatic logic [ST_FLAGS_W-1:0] status_flags(input status_t st);
    return st[ST_FLAGS_W-1:0];
  endfunction

endpackage

// File: rtl/fp_mult_result_q_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset, clears the count
//     clr   - synchronous clear; an increment in the same cycle still counts,
//             so clr && inc leaves the counter at 1
//     inc   - increment request; ignored once the count reaches all-ones
//     cnt   - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d    = '0;
      cnt_d[0] = inc;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fp_mult_result_q.sv
// fp_mult_result_q
//   Registered result stage behind the combinational fp_mult datapath.
//   Queues {z, status} pairs in a DEPTH-entry circular FIFO and keeps sticky
//   exception flags plus saturating event counters. Data is never modified.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. ready/valid are driven from registered state only, never from
//   the partner's signal in the same cycle. The producer must hold its data
//   stable while valid is high and ready is low.
//
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     in_valid / in_ready   - upstream handshake (push)
//     z_in, status_in       - product and status from fp_mult
//     out_valid / out_ready - downstream handshake (pop)
//     z_out, status_out     - head entry of the queue
//     clear_flags           - synchronous clear of sticky flags and counters
//     sticky_flags          - OR of status_in[5:0] over accepted entries
//     nan_cnt, huge_cnt,
//     tiny_cnt, result_cnt  - saturating counts of accepted entries
module fp_mult_result_q
  import fp_mult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      z_in,
  input  logic [7:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      z_out,
  output logic [7:0]       status_out,
  input  logic             clear_flags,
  output logic [5:0]       sticky_flags,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] huge_cnt,
  output logic [CNT_W-1:0] tiny_cnt,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]    z_mem_q  [DEPTH];
  status_t        st_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [5:0]       sticky_q, sticky_d;

  logic push;
  logic pop;

  // Full blocks a push even if a pop happens the same cycle: no pass-through.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // increment wraps modulo DEPTH on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head outputs are never X, even when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        z_mem_q[i]  <= '0;
        st_mem_q[i] <= '0;
      end
    end else if (push) begin
      z_mem_q[wr_ptr_q]  <= z_in;
      st_mem_q[wr_ptr_q] <= status_in;
    end
  end

  assign z_out      = z_mem_q[rd_ptr_q];
  assign status_out = st_mem_q[rd_ptr_q];

  // A clear drops history, but the entry accepted in the clear cycle counts.
  always_comb begin
    sticky_d = clear_flags ? '0 : sticky_q;
    if (push) sticky_d = sticky_d | status_flags(status_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;

  sat_counter #(.W(CNT_W)) u_nan_cnt (
    .clk (clk),
    .rst_n (rst_n),
    .clr (clear_flags),
    .inc (push && status_in[ST_NAN]),
    .cnt (nan_cnt)
  );

  sat_counter #(.W(CNT_W)) u_huge_cnt (
    .clk (clk),
    .rst_n (rst_n),
    .clr (clear_flags),
    .inc (push && status_in[ST_HUGE]),
    .cnt (huge_cnt)
  );

  sat_counter #(.W(CNT_W)) u_tiny_cnt (
    .clk (clk),
    .rst_n (rst_n),
    .clr (clear_flags),
    .inc (push && status_in[ST_TINY]),
    .cnt (tiny_cnt)
  );

  sat_counter #(.W(CNT_W)) u_result_cnt (
    .clk (clk),
    .rst_n (rst_n),
    .clr (clear_flags),
    .inc (push),
    .cnt (result_cnt)
  );

endmodule

// File: tb/tb_fp_mult_result_q.sv
// Bench for fp_mult_result_q with DEPTH=4, CNT_W=4 (so saturation is reachable).
module tb_fp_mult_result_q;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      z_in = '0;
  logic [7:0]       status_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      z_out;
  logic [7:0]       status_out;
  logic             clear_flags = 1'b0;
  logic [5:0]       sticky_flags;
  logic [CNT_W-1:0] nan_cnt, huge_cnt, tiny_cnt, result_cnt;

  fp_mult_result_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .z_in         (z_in),
    .status_in    (status_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .z_out        (z_out),
    .status_out   (status_out),
    .clear_flags  (clear_flags),
    .sticky_flags (sticky_flags),
    .nan_cnt      (nan_cnt),
    .huge_cnt     (huge_cnt),
    .tiny_cnt     (tiny_cnt),
    .result_cnt   (result_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [39:0] exp_q[$];   // {status, z} in acceptance order
  logic [5:0]  m_sticky;
  int          m_nan, m_huge, m_tiny, m_res;

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sticky = '0;
      m_nan = 0; m_huge = 0; m_tiny = 0; m_res = 0;
    end else begin
      bit acc, rem;
      acc = in_valid && (exp_q.size() < DEPTH);
      rem = out_ready && (exp_q.size() > 0);
      if (rem) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({status_in, z_in});
      if (clear_flags) begin
        m_sticky = '0; m_nan = 0; m_huge = 0; m_tiny = 0; m_res = 0;
      end
      if (acc) begin
        m_sticky = m_sticky | status_in[5:0];
        if (status_in[2]) m_nan  = sat_inc(m_nan);
        if (status_in[4]) m_huge = sat_inc(m_huge);
        if (status_in[3]) m_tiny = sat_inc(m_tiny);
        m_res = sat_inc(m_res);
      end
    end
  end

  // ---------------- compare process (every negedge out of reset) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_out_valid", 40'(out_valid), 40'(exp_q.size() != 0));
      check("cmp_in_ready",  40'(in_ready),  40'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) check("cmp_head", {status_out, z_out}, exp_q[0]);
      check("cmp_sticky", 40'(sticky_flags), 40'(m_sticky));
      check("cmp_nan",  40'(nan_cnt),    40'(m_nan));
      check("cmp_huge", 40'(huge_cnt),   40'(m_huge));
      check("cmp_tiny", 40'(tiny_cnt),   40'(m_tiny));
      check("cmp_res",  40'(result_cnt), 40'(m_res));
    end
  end

  // ---------------- driver ----------------
  // Apply inputs, then let one rising edge happen and settle.
  task automatic step(input logic iv, input logic [31:0] z, input logic [7:0] st,
                      input logic ordy, input logic clr);
    in_valid    = iv;
    z_in        = z;
    status_in   = st;
    out_ready   = ordy;
    clear_flags = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset values, checked while reset is held.
    #2;
    check("rst_in_ready",  40'(in_ready), 40'd1);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_z_out",     40'(z_out), 40'd0);
    check("rst_status",    40'(status_out), 40'd0);
    check("rst_sticky",    40'(sticky_flags), 40'd0);
    check("rst_result",    40'(result_cnt), 40'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push then pop.
    step(1'b1, 32'h3F800000, 8'h00, 1'b0, 1'b0);
    check("single_valid", 40'(out_valid), 40'd1);
    check("single_z",     40'(z_out), 40'h3F800000);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    check("single_empty", 40'(out_valid), 40'd0);
    check("single_cnt",   40'(result_cnt), 40'd1);

    // Fill to full, refused 5th push, drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 8'(i), 1'b0, 1'b0);
    check("full_in_ready", 40'(in_ready), 40'd0);
    step(1'b1, 32'hA000_0004, 8'h0, 1'b0, 1'b0);
    check("full_refused_cnt", 40'(result_cnt), 40'd5);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 40'(z_out), 40'(32'hA000_0000 + 32'(i)));
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    end
    check("drain_empty", 40'(out_valid), 40'd0);

    // Full with simultaneous pop: only the pop happens.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 8'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0004, 8'hC0, 1'b1, 1'b0);
    check("fullpop_in_ready", 40'(in_ready), 40'd1);
    check("fullpop_head",     40'(z_out), 40'hB000_0001);
    // Push and pop together for several cycles, wrapping the pointers.
    for (int i = 4; i < 10; i++) step(1'b1, 32'hB000_0000 + 32'(i), 8'hC0, 1'b1, 1'b0);
    check("wrap_in_ready", 40'(in_ready), 40'd1);
    check("wrap_head",     40'(z_out), 40'hB000_0007);
    check("wrap_status",   40'(status_out), 40'hC0);
    for (int i = 7; i < 10; i++) begin
      check("wrap_drain", 40'(z_out), 40'(32'hB000_0000 + 32'(i)));
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    end

    // Flags and clear-with-push.
    step(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    check("clr_sticky", 40'(sticky_flags), 40'd0);
    check("clr_result", 40'(result_cnt), 40'd0);
    step(1'b1, 32'h7FC00000, 8'h04, 1'b1, 1'b0);
    step(1'b1, 32'h7F7FFFFF, 8'h30, 1'b1, 1'b0);
    check("flags_sticky", 40'(sticky_flags), 40'b110100);
    check("flags_nan",    40'(nan_cnt), 40'd1);
    check("flags_huge",   40'(huge_cnt), 40'd1);
    step(1'b1, 32'h00000001, 8'h08, 1'b1, 1'b1);
    check("clrpush_sticky", 40'(sticky_flags), 40'b001000);
    check("clrpush_tiny",   40'(tiny_cnt), 40'd1);
    check("clrpush_nan",    40'(nan_cnt), 40'd0);
    check("clrpush_result", 40'(result_cnt), 40'd1);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Saturation at 2^CNT_W-1.
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 32'h7FC00000 + 32'(i), 8'h04, 1'b1, 1'b0);
    check("sat_nan",    40'(nan_cnt), 40'd15);
    check("sat_result", 40'(result_cnt), 40'd15);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Randomised traffic through the model.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

    // Async reset with three entries queued.
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + 32'(i), 8'h01, 1'b0, 1'b0);
    check("pre_rst_valid", 40'(out_valid), 40'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 40'(out_valid), 40'd0);
    check("async_rst_ready", 40'(in_ready), 40'd1);
    check("async_rst_cnt",   40'(result_cnt), 40'd0);
    #10 rst_n = 1'b1;
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
